// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, read-only instruction cache.
//
// Sits between the fetch port and a 256-bit line-granular memory port.
// Hits respond combinationally in the request cycle. A miss stalls the
// requester while the full 32-byte line is fetched and installed. The
// returning CHECK cycle then hits.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   inst_read      fetch request, held with inst_addr until inst_resp
//   inst_addr      byte address (bits [1:0] ignored)
//   inst_resp      request completes this cycle
//   inst_rdata     instruction word, 0 when inst_resp=0
//   flush          single-cycle pulse, invalidates every line
//   pmem_read      line read request, held until pmem_resp
//   pmem_address   line address, bits [4:0] = 0
//   pmem_resp      line data valid this cycle
//   pmem_rdata     line data, word w in bits [32w+31:32w]
//   hit_count      completed hit responses (wraps)
//   miss_count     misses detected (wraps)
//   state_dbg      current FSM state (0 = CHECK, 1 = FETCH)
//
// Handshake: a fetch request is accepted when inst_read=1 and completes in
// the cycle inst_resp=1. The requester keeps inst_read and inst_addr stable
// until then. On the memory side, pmem_read stays high with a stable
// pmem_address until the single-cycle pmem_resp.
module inst_cache #(
  parameter int S_INDEX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_read,
  input  logic [31:0]  inst_addr,
  output logic         inst_resp,
  output logic [31:0]  inst_rdata,
  input  logic         flush,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic         pmem_resp,
  input  logic [255:0] pmem_rdata,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output logic         state_dbg
);

  localparam int LINES = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic {
    CHECK = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t state, state_next;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [255:0]     data_mem [LINES];

  // Set when a flush arrives while a line is in flight. The fill then lands
  // invalid, so pre-flush data can never become visible.
  logic discard;

  logic [S_INDEX-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [2:0]         word_sel;
  logic               hit;
  logic               miss;

  // The fill is addressed from the latched pmem_address, not inst_addr.
  // A requester that breaks protocol can then only corrupt its own data.
  logic [S_INDEX-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic               fill;

  logic unused_bits;

  assign req_index  = inst_addr[4+S_INDEX:5];
  assign req_tag    = inst_addr[31:5+S_INDEX];
  assign word_sel   = inst_addr[4:2];
  assign fill_index = pmem_address[4+S_INDEX:5];
  assign fill_tag   = pmem_address[31:5+S_INDEX];
  assign unused_bits = ^{inst_addr[1:0], pmem_address[4:0]};

  assign hit       = valid[req_index] && (tag_mem[req_index] == req_tag);
  assign fill      = (state == FETCH) && pmem_resp;
  assign pmem_read = (state == FETCH);
  assign state_dbg = state;

  // Next state and fetch-port outputs.
  always_comb begin
    state_next = state;
    inst_resp  = 1'b0;
    inst_rdata = 32'h0;
    miss       = 1'b0;
    case (state)
      CHECK: begin
        if (inst_read) begin
          if (hit) begin
            inst_resp  = 1'b1;
            inst_rdata = data_mem[req_index][{word_sel, 5'b00000} +: 32];
          end else begin
            miss       = 1'b1;
            state_next = FETCH;
          end
        end
      end
      FETCH: begin
        if (pmem_resp) begin
          state_next = CHECK;
        end
      end
      default: state_next = CHECK;
    endcase
  end

  // Control state, valid bits and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= CHECK;
      valid        <= '0;
      discard      <= 1'b0;
      pmem_address <= 32'h0;
      hit_count    <= 32'h0;
      miss_count   <= 32'h0;
    end else begin
      state <= state_next;

      if (flush) begin
        valid <= '0;
      end
      // The fill follows the flush clear, so a flush in the fill cycle
      // also lands the line invalid.
      if (fill) begin
        valid[fill_index] <= !(discard || flush);
      end

      if (miss) begin
        discard      <= 1'b0;
        pmem_address <= {inst_addr[31:5], 5'b00000};
      end else if ((state == FETCH) && flush) begin
        discard <= 1'b1;
      end

      if (inst_resp) begin
        hit_count <= hit_count + 32'h1;
      end
      if (miss) begin
        miss_count <= miss_count + 32'h1;
      end
    end
  end

  // Line storage. No reset is needed because valid gates every read.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[fill_index] <= pmem_rdata;
      tag_mem[fill_index]  <= fill_tag;
    end
  end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the pipeline's fetch port (inst_read/inst_addr/inst_resp/inst_rdata) and a 256-bit line-granular physical memory port. Hits are served in the request cycle. Misses stall the requester while a full 32-byte line is fetched and installed. Includes a whole-cache invalidate for fence.i/self-modifying-code support and free-running hit/miss counters for performance bring-up.

## Interface
- S_INDEX, 4, index bits; 2**S_INDEX lines of 32 bytes; tag width = 27 - S_INDEX
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- inst_read  in  1  fetch request; held with inst_addr stable until inst_resp
- inst_addr  in  32  byte address; bits [1:0] ignored
- inst_resp  out  1  request complete this cycle
- inst_rdata  out  32  instruction word; 0 when inst_resp=0
- flush  in  1  single-cycle pulse; invalidate all lines
- pmem_read  out  1  line read request; held until pmem_resp
- pmem_address  out  32  line address, bits [4:0]=0; stable while pmem_read=1
- pmem_resp  in  1  line data valid this cycle (single-cycle pulse)
- pmem_rdata  in  256  line data; word w in bits [32w+31:32w]
- hit_count  out  32  number of completed hit responses
- miss_count  out  32  number of misses detected

## Operation
- Address split: offset = inst_addr[4:0], word select = inst_addr[4:2], index = inst_addr[4+S_INDEX:5], tag = inst_addr[31:5+S_INDEX].
- Storage: per line a valid bit, a tag and 256 data bits, all in flops; combinational read.
- FSM states: CHECK and FETCH. Reset state is CHECK.
- CHECK: if inst_read=1 and valid[index]=1 and tag matches:
  - inst_resp=1 in the same cycle;
  - inst_rdata = the selected word;
  - hit_count += 1.
- CHECK, miss (inst_read=1, no hit):
  - miss_count += 1;
  - pmem_address <= {inst_addr[31:5], 5'b0};
  - clear the discard flag;
  - next state FETCH.
- CHECK with inst_read=0: idle, no state change.
- FETCH:
  - pmem_read=1 (Moore output).
  - On pmem_resp=1: write data and tag at the index, then set valid=1 unless the discard flag is set (or flush=1 in that same cycle). Next state CHECK.
  - inst_resp is never asserted in FETCH.
- After a fill, the returning CHECK cycle hits, so the requester sees inst_resp then.
- Replacement: direct-mapped. A fill overwrites the line at its index unconditionally.
- flush=1, any state: all valid bits cleared at the next edge.
  - A flush in CHECK takes priority over a same-cycle hit: the hit still responds (combinational), but the line is invalid afterwards.
  - A flush during FETCH sets the discard flag, so the in-flight line is installed invalid. The returning CHECK then misses again and refetches. This is required so that stale pre-flush data is never marked valid.
- Counters: 32-bit, wrap from 0xFFFF_FFFF to 0. They count regardless of flush.
- Reset (async, any state):
  - state=CHECK, all valid=0, discard=0;
  - pmem_read=0, pmem_address=0;
  - inst_resp=0, inst_rdata=0;
  - hit_count=0, miss_count=0.
  - A pending memory fetch is abandoned. Memory must tolerate the dropped request.

## Timing
- Hit latency: 0 cycles (inst_resp in the cycle inst_read is presented with a hitting address).
- Miss latency, with memory responding L cycles after pmem_read rises (pmem_resp in cycle L, where L≥0):
  - cycle 0: miss detected;
  - cycles 1..1+L: pmem_read high;
  - cycle 2+L: inst_resp.
- pmem_read deasserts the cycle after pmem_resp. There is no back-to-back pmem request without at least one CHECK cycle in between.
- A requester changing inst_addr before inst_resp is a protocol violation; behaviour is then undefined but must not hang the FSM.

## Test plan
- Cold miss: reset, inst_read=1, addr 0x0000_0064, memory L=3 returns a line with word1=0x0000_0013.
  - Expect pmem_address=0x0000_0060 and pmem_read for 4 cycles.
  - Expect inst_resp with inst_rdata=0x0000_0013 at cycle 5.
  - Expect miss_count=1.
- Hit after fill: then request 0x0000_0060..0x0000_007C in consecutive cycles.
  - Expect 8 consecutive single-cycle inst_resp, no pmem_read, hit_count=9.
- Conflict eviction (S_INDEX=4): fill 0x0000_0000, then 0x0000_0200 (same index, different tag), then 0x0000_0000 again.
  - Expect 3 misses, each fetching the correct line address.
- Flush: fill a line, pulse flush, re-request the same address → miss and refetch.
  - Pulse flush during FETCH → fill discarded, a second pmem_read issued for the same line, then inst_resp.
- Reset mid-fetch: assert rst while pmem_read=1 → pmem_read, inst_resp and counters 0 immediately (asynchronously); the next request misses.
- Counter wrap: force hit_count to 0xFFFF_FFFF via a bench backdoor, do one hit → hit_count=0.
